// File: rtl/volatility_accum.sv
`default_nettype none
// ---- volatility_accum: per-stock circular sample window with rolling sum, sum of squares
// ---- and division-free scaled variance (count*sumsq - sum^2), 3-cycle pipeline; rev 1.0
module volatility_accum #(
   parameter int NUM_STOCKS  = 4,
   parameter int BUFFER_SIZE = 20,
   parameter int DATA_WIDTH  = 32
) (
   input  logic                                                  i_clk,
   input  logic                                                  i_reset_n,
   input  logic [$clog2(NUM_STOCKS)-1:0]                         i_stock_id,
   input  logic [$clog2(NUM_STOCKS*BUFFER_SIZE)-1:0]             i_write_address,
   input  logic                                                  i_addr_valid,
   input  logic [DATA_WIDTH-1:0]                                 i_price,
   output logic [$clog2(NUM_STOCKS)-1:0]                         o_stock_id,
   output logic [$clog2(BUFFER_SIZE+1)-1:0]                      o_count,
   output logic [DATA_WIDTH+$clog2(BUFFER_SIZE+1)-1:0]           o_sum,
   output logic [2*(DATA_WIDTH+$clog2(BUFFER_SIZE+1))-1:0]       o_var_scaled,
   output logic                                                  o_valid
);
   localparam int SW    = $clog2(NUM_STOCKS);
   localparam int AW    = $clog2(NUM_STOCKS*BUFFER_SIZE);
   localparam int CW    = $clog2(BUFFER_SIZE+1);
   localparam int DEPTH = NUM_STOCKS*BUFFER_SIZE;
   localparam int SUM_W = DATA_WIDTH+CW;
   localparam int SQ_W  = 2*DATA_WIDTH+CW;
   localparam int VAR_W = 2*SUM_W;
   localparam logic [CW-1:0] FULL_COUNT = CW'(BUFFER_SIZE);

   logic [DATA_WIDTH-1:0] ram [DEPTH];

   logic [DATA_WIDTH-1:0] rd_data_q, rd_data_d;
   logic                  s2_valid_q, s2_valid_d;
   logic [SW-1:0]         s2_stock_q, s2_stock_d;
   logic [AW-1:0]         s2_addr_q, s2_addr_d;
   logic [DATA_WIDTH-1:0] s2_price_q, s2_price_d;

   logic [CW-1:0]         count_q [NUM_STOCKS];
   logic [CW-1:0]         count_d [NUM_STOCKS];
   logic [SUM_W-1:0]      sum_q   [NUM_STOCKS];
   logic [SUM_W-1:0]      sum_d   [NUM_STOCKS];
   logic [SQ_W-1:0]       sumsq_q [NUM_STOCKS];
   logic [SQ_W-1:0]       sumsq_d [NUM_STOCKS];

   logic                  s3_valid_q, s3_valid_d;
   logic [SW-1:0]         s3_stock_q, s3_stock_d;
   logic [CW-1:0]         s3_count_q, s3_count_d;
   logic [SUM_W-1:0]      s3_sum_q, s3_sum_d;
   logic [SQ_W-1:0]       s3_sumsq_q, s3_sumsq_d;

   logic                  out_valid_q, out_valid_d;
   logic [SW-1:0]         out_stock_q, out_stock_d;
   logic [CW-1:0]         out_count_q, out_count_d;
   logic [SUM_W-1:0]      out_sum_q, out_sum_d;
   logic [VAR_W-1:0]      out_var_q, out_var_d;

   logic                  full;
   logic [CW-1:0]         cur_count, new_count;
   logic [SUM_W-1:0]      new_sum, evict_sum;
   logic [SQ_W-1:0]       new_sumsq, evict_sq;
   logic [VAR_W-1:0]      var_full;

   // S1: synchronous read, write-first when it collides with the S2 write
   always_comb begin
      rd_data_d  = rd_data_q;
      s2_valid_d = i_addr_valid;
      s2_stock_d = s2_stock_q;
      s2_addr_d  = s2_addr_q;
      s2_price_d = s2_price_q;
      if (i_addr_valid) begin
         rd_data_d  = ram[i_write_address];
         if (s2_valid_q && (s2_addr_q == i_write_address)) begin
            rd_data_d = s2_price_q;
         end
         s2_stock_d = i_stock_id;
         s2_addr_d  = i_write_address;
         s2_price_d = i_price;
      end
   end

   // S2: the evicted sample only counts once the window is full
   always_comb begin
      cur_count  = count_q[s2_stock_q];
      full       = (cur_count == FULL_COUNT);
      evict_sum  = full ? SUM_W'(rd_data_q) : '0;
      evict_sq   = full ? SQ_W'(rd_data_q) * SQ_W'(rd_data_q) : '0;
      new_sum    = sum_q[s2_stock_q] + SUM_W'(s2_price_q) - evict_sum;
      new_sumsq  = sumsq_q[s2_stock_q] + SQ_W'(s2_price_q) * SQ_W'(s2_price_q) - evict_sq;
      new_count  = full ? cur_count : cur_count + CW'(1);
      count_d    = count_q;
      sum_d      = sum_q;
      sumsq_d    = sumsq_q;
      s3_valid_d = s2_valid_q;
      s3_stock_d = s3_stock_q;
      s3_count_d = s3_count_q;
      s3_sum_d   = s3_sum_q;
      s3_sumsq_d = s3_sumsq_q;
      if (s2_valid_q) begin
         count_d[s2_stock_q] = new_count;
         sum_d[s2_stock_q]   = new_sum;
         sumsq_d[s2_stock_q] = new_sumsq;
         s3_stock_d          = s2_stock_q;
         s3_count_d          = new_count;
         s3_sum_d            = new_sum;
         s3_sumsq_d          = new_sumsq;
      end
   end

   always_comb begin
      var_full    = VAR_W'(s3_count_q) * VAR_W'(s3_sumsq_q) - VAR_W'(s3_sum_q) * VAR_W'(s3_sum_q);
      out_valid_d = s3_valid_q;
      out_stock_d = out_stock_q;
      out_count_d = out_count_q;
      out_sum_d   = out_sum_q;
      out_var_d   = out_var_q;
      if (s3_valid_q) begin
         out_stock_d = s3_stock_q;
         out_count_d = s3_count_q;
         out_sum_d   = s3_sum_q;
         out_var_d   = var_full;
      end
   end

   always_ff @(posedge i_clk) begin
      if (i_reset_n && s2_valid_q) begin
         ram[s2_addr_q] <= s2_price_q;
      end
   end

   always_ff @(posedge i_clk) begin
      if (!i_reset_n) begin
         rd_data_q   <= '0;
         s2_valid_q  <= 1'b0;
         s2_stock_q  <= '0;
         s2_addr_q   <= '0;
         s2_price_q  <= '0;
         for (int i = 0; i < NUM_STOCKS; i++) begin
            count_q[i] <= '0;
            sum_q[i]   <= '0;
            sumsq_q[i] <= '0;
         end
         s3_valid_q  <= 1'b0;
         s3_stock_q  <= '0;
         s3_count_q  <= '0;
         s3_sum_q    <= '0;
         s3_sumsq_q  <= '0;
         out_valid_q <= 1'b0;
         out_stock_q <= '0;
         out_count_q <= '0;
         out_sum_q   <= '0;
         out_var_q   <= '0;
      end else begin
         rd_data_q   <= rd_data_d;
         s2_valid_q  <= s2_valid_d;
         s2_stock_q  <= s2_stock_d;
         s2_addr_q   <= s2_addr_d;
         s2_price_q  <= s2_price_d;
         count_q     <= count_d;
         sum_q       <= sum_d;
         sumsq_q     <= sumsq_d;
         s3_valid_q  <= s3_valid_d;
         s3_stock_q  <= s3_stock_d;
         s3_count_q  <= s3_count_d;
         s3_sum_q    <= s3_sum_d;
         s3_sumsq_q  <= s3_sumsq_d;
         out_valid_q <= out_valid_d;
         out_stock_q <= out_stock_d;
         out_count_q <= out_count_d;
         out_sum_q   <= out_sum_d;
         out_var_q   <= out_var_d;
      end
   end

   assign o_valid      = out_valid_q;
   assign o_stock_id   = out_stock_q;
   assign o_count      = out_count_q;
   assign o_sum        = out_sum_q;
   assign o_var_scaled = out_var_q;

endmodule
`default_nettype wire

// File: tb/tb_volatility_accum.sv
`default_nettype none
// ---- tb_volatility_accum: randomized scoreboard bench for volatility_accum against a
// ---- sample-history window model; rev 1.0
module tb_volatility_accum;
   localparam int NS    = 4;
   localparam int BS    = 4;
   localparam int DW    = 32;
   localparam int SW    = $clog2(NS);
   localparam int AW    = $clog2(NS*BS);
   localparam int CW    = $clog2(BS+1);
   localparam int SUM_W = DW+CW;
   localparam int VAR_W = 2*SUM_W;

   logic              i_clk = 1'b0;
   logic              i_reset_n = 1'b0;
   logic [SW-1:0]     i_stock_id = '0;
   logic [AW-1:0]     i_write_address = '0;
   logic              i_addr_valid = 1'b0;
   logic [DW-1:0]     i_price = '0;
   logic [SW-1:0]     o_stock_id;
   logic [CW-1:0]     o_count;
   logic [SUM_W-1:0]  o_sum;
   logic [VAR_W-1:0]  o_var_scaled;
   logic              o_valid;

   volatility_accum #(.NUM_STOCKS(NS), .BUFFER_SIZE(BS), .DATA_WIDTH(DW)) dut (
      .i_clk           (i_clk),
      .i_reset_n       (i_reset_n),
      .i_stock_id      (i_stock_id),
      .i_write_address (i_write_address),
      .i_addr_valid    (i_addr_valid),
      .i_price         (i_price),
      .o_stock_id      (o_stock_id),
      .o_count         (o_count),
      .o_sum           (o_sum),
      .o_var_scaled    (o_var_scaled),
      .o_valid         (o_valid)
   );

   always #5 i_clk = ~i_clk;

   typedef struct {
      int          stock;
      logic [DW-1:0] price;
   } sample_t;

   typedef struct {
      int           stock;
      int           count;
      logic [127:0] sum;
      logic [127:0] var_s;
      int           due;
   } exp_t;

   sample_t      hist[$];
   exp_t         sb[$];
   int           wp[NS];
   int           cyc = 0;
   int           n_tests = 0;
   int           n_fail = 0;
   logic [127:0] last_count[NS];
   logic [127:0] last_sum[NS];
   logic [127:0] last_var[NS];
   logic [DW-1:0] pmax = '1;

   always @(posedge i_clk) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [127:0] act, input logic [127:0] req);
      n_tests++;
      if (act !== req) begin
         n_fail++;
         $display("FAIL %s: actual=%0d required=%0d", name, act, req);
      end
   endtask

   // Window = the last BS samples of this stock since reset, straight from the history.
   task automatic model(input int s, output exp_t e);
      int           cnt;
      logic [127:0] sm, sq;
      cnt = 0; sm = '0; sq = '0;
      for (int k = hist.size() - 1; k >= 0 && cnt < BS; k--) begin
         if (hist[k].stock == s) begin
            cnt++;
            sm += 128'(hist[k].price);
            sq += 128'(hist[k].price) * 128'(hist[k].price);
         end
      end
      e.stock = s;
      e.count = cnt;
      e.sum   = sm;
      e.var_s = 128'(cnt) * sq - sm * sm;
      e.due   = cyc + 3;
   endtask

   task automatic send(input int s, input logic [DW-1:0] p);
      exp_t    e;
      sample_t h;
      @(negedge i_clk);
      i_addr_valid    = 1'b1;
      i_stock_id      = SW'(s);
      i_write_address = AW'(s*BS + wp[s]);
      i_price         = p;
      wp[s]           = (wp[s] + 1) % BS;
      h.stock = s;
      h.price = p;
      hist.push_back(h);
      model(s, e);
      sb.push_back(e);
   endtask

   task automatic idle(input int n);
      repeat (n) begin
         @(negedge i_clk);
         i_addr_valid    = 1'b0;
         i_stock_id      = SW'($urandom);
         i_write_address = AW'($urandom);
         i_price         = $urandom;
      end
   endtask

   task automatic drain();
      int t;
      idle(1);
      t = 0;
      while (sb.size() != 0 && t < 20) begin
         @(negedge i_clk);
         t++;
      end
      chk("drain_pending", 128'(sb.size()), 128'(0));
   endtask

   task automatic do_reset();
      @(negedge i_clk);
      #1;
      i_reset_n    = 1'b0;
      i_addr_valid = 1'b0;
      sb.delete();
      hist.delete();
      for (int s = 0; s < NS; s++) wp[s] = 0;
      repeat (2) @(negedge i_clk);
      chk("rst_valid", 128'(o_valid), 128'(0));
      chk("rst_stock", 128'(o_stock_id), 128'(0));
      chk("rst_count", 128'(o_count), 128'(0));
      chk("rst_sum", 128'(o_sum), 128'(0));
      chk("rst_var", 128'(o_var_scaled), 128'(0));
      i_reset_n = 1'b1;
   endtask

   // Monitor: every o_valid must match the oldest outstanding expectation on its due cycle.
   always @(negedge i_clk) begin
      if (o_valid) begin
         last_count[o_stock_id] = 128'(o_count);
         last_sum[o_stock_id]   = 128'(o_sum);
         last_var[o_stock_id]   = 128'(o_var_scaled);
         if (sb.size() == 0) begin
            chk("unexpected_valid", 128'(o_valid), 128'(0));
         end else begin
            exp_t e;
            e = sb.pop_front();
            chk("out_stock", 128'(o_stock_id), 128'(e.stock));
            chk("out_count", 128'(o_count), 128'(e.count));
            chk("out_sum", 128'(o_sum), e.sum);
            chk("out_var", 128'(o_var_scaled), e.var_s);
            chk("latency", 128'(cyc), 128'(e.due));
         end
      end
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: actual=timeout required=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int s;
      logic [DW-1:0] p;
      for (int k = 0; k < NS; k++) wp[k] = 0;
      repeat (3) @(negedge i_clk);
      do_reset();

      send(0, 10); send(0, 20); send(0, 30);
      drain();
      chk("t1_count", last_count[0], 3);
      chk("t1_sum", last_sum[0], 60);
      chk("t1_var", last_var[0], 600);

      for (int k = 1; k <= 5; k++) send(1, DW'(k));
      drain();
      chk("t2_count", last_count[1], 4);
      chk("t2_sum", last_sum[1], 14);
      chk("t2_var", last_var[1], 20);

      for (int k = 0; k < 8; k++) send(2, 100);
      drain();
      chk("t3_count", last_count[2], BS);
      chk("t3_sum", last_sum[2], 100*BS);
      chk("t3_var", last_var[2], 0);

      do_reset();
      send(0, 5); send(3, 7); send(0, 9); send(3, 11);
      drain();
      chk("t4_s0_sum", last_sum[0], 14);
      chk("t4_s0_var", last_var[0], 16);
      chk("t4_s3_sum", last_sum[3], 18);
      chk("t4_s3_var", last_var[3], 16);

      send(1, 123); send(2, 456);
      do_reset();
      send(0, 50);
      drain();
      chk("t5_count", last_count[0], 1);
      chk("t5_sum", last_sum[0], 50);
      chk("t5_var", last_var[0], 0);

      for (int k = 0; k < BS + 2; k++) send(3, pmax);
      drain();
      chk("t6_sum", last_sum[3], 128'(BS) * 128'(pmax));
      chk("t6_var", last_var[3], 0);
      for (int k = 0; k < 2*BS; k++) send(3, (k % 3 == 1) ? '0 : pmax);
      drain();

      for (int k = 0; k < 400; k++) begin
         s = $urandom_range(0, NS-1);
         case ($urandom_range(0, 3))
            0: p = pmax;
            1: p = DW'($urandom_range(0, 15));
            2: p = $urandom;
            default: p = pmax - DW'($urandom_range(0, 3));
         endcase
         send(s, p);
         if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 3));
         if (k == 200) do_reset();
      end
      drain();

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
`default_nettype wire
